// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Byte-wide UART transmitter fronted by a small transmit FIFO. Bytes pushed
//   with wr_uart are queued and serialized LSB first, back-to-back while the
//   FIFO has data.
//
//   Optional build macro: UART_TX_PARITY_EN
//     undefined -> 8N1 frames (start, 8 data, stop)
//     defined   -> 8E1 frames (start, 8 data, even parity, stop)
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit
//   FIFO_ADDR_W   FIFO depth is 2**FIFO_ADDR_W entries
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   wr_uart   one-cycle push request for w_data
//   w_data    byte to transmit
//   tx_full   FIFO holds depth entries
//   tx_empty  FIFO holds no entries
//   tx_busy   serializer is not idle
//   tx        registered serial line, idle high
//
// Serializer states
//   state  | meaning
//   IDLE   | line idle high, waiting for FIFO data
//   START  | start bit (low)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (UART_TX_PARITY_EN builds only)
//   STOP   | stop bit (high); pops the next byte at its end if one is queued

module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_ADDR_W  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_uart,
  input  logic [7:0] w_data,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx
);

  localparam int DEPTH = 2 ** FIFO_ADDR_W;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]     BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_W:0] FIFO_DEPTH = (FIFO_ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]             mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic [FIFO_ADDR_W:0]   count;
  logic                   push;
  logic                   pop;

  assign tx_full  = (count == FIFO_DEPTH);
  assign tx_empty = (count == '0);

  // A write while full is dropped even when the serializer pops that cycle.
  assign push = wr_uart & ~tx_full & ~reset;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (FIFO_ADDR_W + 1)'(1);
        2'b01:   count <= count - (FIFO_ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_done;
  logic             tx_bit;

  assign bit_done = (bit_cnt == BIT_LAST);
  assign tx_busy  = (state != IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_bit     = 1'b1;
    case (state)
      IDLE: begin
        tx_bit = 1'b1;
        if (!tx_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        tx_bit = shreg[0];
        if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        // shreg has been rotated a full turn, so it holds the original byte.
        tx_bit = ^shreg;
        if (bit_done) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        tx_bit = 1'b1;
        if (bit_done) begin
          if (!tx_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state <= state_next;
      // tx is registered from the current state, so the line lags the state
      // register by one cycle; every bit still lasts CLKS_PER_BIT cycles.
      tx    <= tx_bit;

      if ((state_next != state) || (state == IDLE)) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (pop) begin
        shreg <= mem[rd_ptr];
      end else if ((state == DATA) && bit_done) begin
        // Rotate rather than shift so the byte is intact again after 8 bits.
        shreg   <= {shreg[0], shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_ADDR_W (AW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_uart (wr_uart),
    .w_data  (w_data),
    .tx_full (tx_full),
    .tx_empty(tx_empty),
    .tx_busy (tx_busy),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: queue of accepted bytes plus the per-cycle line level
  // the serializer will present; the line is seen one edge after the state.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  logic [7:0] m_acc[$];
  logic       m_wave[$];
  logic       m_tx, m_busy, m_empty, m_full;
  logic       m_rst_seen = 1'b0;
  bit         chk_en = 1'b0;
  bit         m_pop, m_push;
  logic [7:0] m_byte;

  function automatic void append_frame(input logic [7:0] b);
    for (int c = 0; c < CPB; c++) m_wave.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < CPB; c++) m_wave.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int c = 0; c < CPB; c++) m_wave.push_back(^b);
`endif
    for (int c = 0; c < CPB; c++) m_wave.push_back(1'b1);
  endfunction

  always @(posedge clk) begin
    m_rst_seen = reset;
    if (reset) begin
      m_q.delete();
      m_wave.delete();
      m_tx = 1'b1;
    end else begin
      m_pop  = (m_wave.size() <= 1) && (m_q.size() > 0);
      m_push = wr_uart && (m_q.size() < DEPTH);
      m_tx   = (m_wave.size() > 0) ? m_wave.pop_front() : 1'b1;
      if (m_pop) begin
        m_byte = m_q.pop_front();
        append_frame(m_byte);
      end
      if (m_push) begin
        m_q.push_back(w_data);
        m_acc.push_back(w_data);
      end
    end
    m_busy  = (m_wave.size() != 0);
    m_empty = (m_q.size() == 0);
    m_full  = (m_q.size() == DEPTH);
    chk_en  = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx",       32'(tx),       32'(m_tx));
      chk("tx_busy",  32'(tx_busy),  32'(m_busy));
      chk("tx_empty", 32'(tx_empty), 32'(m_empty));
      chk("tx_full",  32'(tx_full),  32'(m_full));
    end
  end

  // ---------------------------------------------------------------------------
  // Line receiver: recovers bytes from tx by mid-bit sampling.
  // ---------------------------------------------------------------------------
  logic [7:0] rx_q[$];
  logic       rx_par[$];
  bit         rx_active = 1'b0;
  int         rx_t = 0;
  int         rx_i;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    if (m_rst_seen) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (chk_en && tx === 1'b0) begin
        rx_active = 1'b1;
        rx_t      = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % CPB == CPB / 2) begin
        rx_i = rx_t / CPB;
        if (rx_i >= 1 && rx_i <= 8) rx_byte[rx_i-1] = tx;
`ifdef UART_TX_PARITY_EN
        if (rx_i == 9) rx_par.push_back(tx);
`endif
        if (rx_i == FRAME_BITS - 1) begin
          chk("rx_stop_bit", 32'(tx), 32'd1);
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input int budget);
    int k = 0;
    while ((tx_busy || !tx_empty) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle_busy", 32'(tx_busy), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_rx(input string nm, input int base, input int n, input logic [7:0] e [8]);
    chk({nm, "_count"}, 32'(rx_q.size() - base), 32'(n));
    for (int k = 0; k < n; k++)
      if (base + k < rx_q.size()) chk(nm, 32'(rx_q[base+k]), 32'(e[k]));
  endtask

  task automatic busy_count(input string nm, input int exp);
    int cnt = 0;
    while (tx_busy && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    chk(nm, 32'(cnt), 32'(exp));
  endtask

  logic [7:0] ev [8];
  logic [7:0] samp;
  logic [9:0] frame_bits;
  int base, abase;

  initial begin
    reset   = 1'b1;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx",    32'(tx),       32'd1);
    chk("rst_busy",  32'(tx_busy),  32'd0);
    chk("rst_empty", 32'(tx_empty), 32'd1);
    chk("rst_full",  32'(tx_full),  32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x55: latency, bit pattern and return to idle.
    base = rx_q.size();
    wr_uart = 1'b1; w_data = 8'h55;
    @(negedge clk);
    wr_uart = 1'b0; w_data = 8'hFF;
    chk("t1_empty_after_write", 32'(tx_empty), 32'd0);
    chk("t1_tx_edge1", 32'(tx), 32'd1);
    @(negedge clk);
    chk("t1_tx_edge1b", 32'(tx), 32'd1);
    chk("t1_busy_edge1", 32'(tx_busy), 32'd1);
    @(negedge clk);
    chk("t1_tx_edge2", 32'(tx), 32'd0);
    @(negedge clk);
    frame_bits[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(negedge clk);
      frame_bits[i] = tx;
    end
`ifndef UART_TX_PARITY_EN
    chk("t1_frame_bits", 32'(frame_bits), 32'h2AA);
    repeat (2) @(negedge clk);
    chk("t1_busy_end", 32'(tx_busy), 32'd0);
    chk("t1_empty_end", 32'(tx_empty), 32'd1);
`endif
    wait_idle(200);
    ev = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_rx("t1_rx", base, 1, ev);

    // Three back-to-back frames.
    base = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      wr_uart = 1'b1; w_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    wr_uart = 1'b0;
`ifndef UART_TX_PARITY_EN
    busy_count("t2_busy_cycles", 119);
`endif
    wait_idle(600);
    ev = '{8'h41, 8'h42, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_rx("t2_rx", base, 3, ev);

    // Overfill: 0x01..0x06, the sixth is dropped.
    base = rx_q.size();
    for (int i = 1; i <= 6; i++) begin
      wr_uart = 1'b1; w_data = 8'(i);
      @(negedge clk);
      if (i == 4) chk("t3_full_after_4", 32'(tx_full), 32'd0);
      if (i == 5) chk("t3_full_after_5", 32'(tx_full), 32'd1);
      if (i == 6) chk("t3_full_after_6", 32'(tx_full), 32'd1);
    end
    wr_uart = 1'b0;
    wait_idle(1000);
    ev = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
    check_rx("t3_rx", base, 5, ev);

    // Reset in the middle of DATA of 0xA5 with 0x11 queued; a write during
    // reset must be ignored.
    base = rx_q.size();
    wr_uart = 1'b1; w_data = 8'hA5;
    @(negedge clk);
    w_data = 8'h11;
    @(negedge clk);
    wr_uart = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1; wr_uart = 1'b1; w_data = 8'h99;
    @(negedge clk);
    reset = 1'b0; wr_uart = 1'b0;
    chk("t4_tx_after_rst", 32'(tx), 32'd1);
    chk("t4_empty_after_rst", 32'(tx_empty), 32'd1);
    chk("t4_busy_after_rst", 32'(tx_busy), 32'd0);
    repeat (60) @(negedge clk);
    chk("t4_busy_later", 32'(tx_busy), 32'd0);
    chk("t4_no_frames", 32'(rx_q.size() - base), 32'd0);

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 -> 1, 0x03 -> 0, 44-cycle frames.
    base = rx_q.size();
    abase = rx_par.size();
    wr_uart = 1'b1; w_data = 8'h07;
    @(negedge clk);
    w_data = 8'h03;
    @(negedge clk);
    wr_uart = 1'b0;
    busy_count("t5_busy_cycles", 88);
    wait_idle(400);
    ev = '{8'h07, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_rx("t5_rx", base, 2, ev);
    chk("t5_par_count", 32'(rx_par.size() - abase), 32'd2);
    if (rx_par.size() >= abase + 2) begin
      chk("t5_par_07", 32'(rx_par[abase]), 32'd1);
      chk("t5_par_03", 32'(rx_par[abase+1]), 32'd0);
    end
`endif

    // Continuous writes with changing data: exercises writes while full,
    // including cycles where the serializer pops at the same edge.
    base  = rx_q.size();
    abase = m_acc.size();
    for (int i = 0; i < 150; i++) begin
      wr_uart = 1'b1; w_data = 8'(i * 37 + 5);
      @(negedge clk);
    end
    wr_uart = 1'b0;
    wait_idle(1500);
    chk("t6_rx_count", 32'(rx_q.size() - base), 32'(m_acc.size() - abase));
    for (int k = 0; k < m_acc.size() - abase; k++)
      if (base + k < rx_q.size())
        chk("t6_rx_byte", 32'(rx_q[base+k]), 32'(m_acc[abase+k]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
